// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the button input stage and the LED shifter that consumes it.
// No logic here; defaults match a 40 MHz core clock with a 1 kHz sample rate.
package btn_conditioner_pkg;

   localparam int unsigned DIV_COUNT_DEFAULT = 40000;
   localparam int unsigned DB_DEPTH_DEFAULT  = 4;
   localparam int unsigned CNT_W_DEFAULT     = 16;
   localparam int unsigned PRESS_W           = 8;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: tick high for one cycle every DIV_COUNT cycles, first in cycle DIV_COUNT-1.
// Latency: tick decoded straight from the count register; no backpressure (free-running).
module clk_en_div
   import btn_conditioner_pkg::*;
#(
   parameter int unsigned DIV_COUNT = DIV_COUNT_DEFAULT,
   parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Gated by rst so a divide-by-1 instance stays quiet while reset is held.
   assign tick = (cnt == LAST) && !rst;

endmodule

// File: rtl/btn_conditioner.sv
// Raw push-button to clean tick/level/pulse/toggle/press_cnt; level settles 2 + up to DB_DEPTH*DIV_COUNT cycles after the raw edge.
// No backpressure: outputs are registered strobes/levels the shifter samples as it likes.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int unsigned DIV_COUNT = DIV_COUNT_DEFAULT,
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter int unsigned DB_DEPTH  = DB_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_raw,
   output logic               tick,
   output logic               level,
   output logic               pulse,
   output logic               toggle,
   output logic [PRESS_W-1:0] press_cnt
);

   logic                btn_meta;
   logic                btn_s;
   logic [DB_DEPTH-1:0] sh;
   logic [DB_DEPTH-1:0] sh_next;

   clk_en_div #(
      .DIV_COUNT (DIV_COUNT),
      .CNT_W     (CNT_W)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      sh_next = {sh[DB_DEPTH-2:0], btn_s};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta  <= 1'b0;
         btn_s     <= 1'b0;
         sh        <= '0;
         level     <= 1'b0;
         pulse     <= 1'b0;
         toggle    <= 1'b0;
         press_cnt <= '0;
      end else begin
         btn_meta <= btn_raw;
         btn_s    <= btn_meta;
         pulse    <= 1'b0;
         if (tick) begin
            sh <= sh_next;
            // A press is the all-ones window seen while level is still low,
            // so pulse stays single-cycle even when a tick arrives every cycle.
            if (&sh_next) begin
               level <= 1'b1;
               if (!level) begin
                  pulse     <= 1'b1;
                  toggle    <= ~toggle;
                  press_cnt <= press_cnt + PRESS_W'(1);
               end
            end else if (~|sh_next) begin
               level <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner at DIV_COUNT=4, DB_DEPTH=3 with a per-cycle reference model.
module tb_btn_conditioner;

   localparam int unsigned DIV = 4;
   localparam int unsigned DB  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_raw = 1'b0;
   logic       tick, level, pulse, toggle;
   logic [7:0] press_cnt;

   int errors = 0;
   int checks = 0;

   btn_conditioner #(
      .DIV_COUNT (DIV),
      .CNT_W     (4),
      .DB_DEPTH  (DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .tick      (tick),
      .level     (level),
      .pulse     (pulse),
      .toggle    (toggle),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycle index since reset, raw-button history and the
   // last DB tick samples; level follows a unanimous sample window.
   int unsigned m_cyc = 0;
   bit          hist[$];
   bit          samp[$];
   bit          m_level = 1'b0, m_pulse = 1'b0, m_toggle = 1'b0;
   int unsigned m_presses = 0;

   function automatic bit m_tick();
      return !rst && ((m_cyc % DIV) == DIV - 1);
   endfunction

   function automatic int ones_in_window();
      int n = 0;
      foreach (samp[i]) if (samp[i]) n++;
      return n;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_cyc = 0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            samp.delete();
            for (int i = 0; i < DB; i++) samp.push_back(1'b0);
            m_level = 1'b0; m_pulse = 1'b0; m_toggle = 1'b0; m_presses = 0;
         end else begin
            m_pulse = 1'b0;
            if ((m_cyc % DIV) == DIV - 1) begin
               samp.push_back(hist[hist.size() - 2]);
               void'(samp.pop_front());
               if (ones_in_window() == DB) begin
                  if (!m_level) begin
                     m_pulse = 1'b1;
                     m_toggle = ~m_toggle;
                     m_presses++;
                  end
                  m_level = 1'b1;
               end else if (ones_in_window() == 0) begin
                  m_level = 1'b0;
               end
            end
            hist.push_back(btn_raw);
            if (hist.size() > 3) void'(hist.pop_front());
            m_cyc++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("cycle_model",
               32'({tick, level, pulse, toggle, press_cnt}),
               32'({m_tick(), m_level, m_pulse, m_toggle, 8'(m_presses % 256)}));
      end
   end

   task automatic go();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({tick, level, pulse, toggle, press_cnt}), 32'd0);
   endtask

   // Holds rst for n edges; returns in cycle 0 with rst low.
   task automatic do_reset(input int n, input logic raw);
      rst = 1'b1;
      btn_raw = raw;
      for (int i = 0; i < n; i++) begin
         go();
         check_all_zero("reset_outputs");
      end
      rst = 1'b0;
      #1;
   endtask

   int npulse;

   initial begin
      // 1: reset with button held, then tick cadence
      do_reset(3, 1'b1);
      btn_raw = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         check("tick_cadence", 32'(tick), 32'((k == 3) || (k == 7) || (k == 11)));
         go();
      end

      // 2: clean press from cycle 0
      do_reset(1, 1'b0);
      btn_raw = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("press_level", 32'(level), 32'(k >= 12));
         check("press_pulse", 32'(pulse), 32'(k == 12));
         go();
      end
      check("press_toggle", 32'(toggle), 32'd1);
      check("press_cnt_1", 32'(press_cnt), 32'd1);

      // 4: release, starting in cycle 16
      btn_raw = 1'b0;
      for (int k = 16; k < 32; k++) begin
         check("release_level", 32'(level), 32'(k < 28));
         check("release_pulse", 32'(pulse), 32'd0);
         go();
      end
      check("release_toggle", 32'(toggle), 32'd1);
      check("release_cnt", 32'(press_cnt), 32'd1);

      // 3: 6-cycle bounce yields only two high samples
      do_reset(1, 1'b0);
      for (int k = 0; k < 24; k++) begin
         btn_raw = (k < 6);
         check("bounce_level", 32'(level), 32'd0);
         check("bounce_pulse", 32'(pulse), 32'd0);
         go();
      end
      check("bounce_toggle", 32'(toggle), 32'd0);
      check("bounce_cnt", 32'(press_cnt), 32'd0);

      // 5: 256 presses wrap the counter
      do_reset(1, 1'b0);
      npulse = 0;
      for (int i = 0; i < 256; i++) begin
         btn_raw = 1'b1;
         for (int k = 0; k < 16; k++) begin
            if (pulse) npulse++;
            go();
         end
         btn_raw = 1'b0;
         for (int k = 0; k < 16; k++) begin
            if (pulse) npulse++;
            go();
         end
         check("wrap_cnt_step", 32'(press_cnt), 32'((i + 1) % 256));
      end
      check("wrap_pulses", 32'(npulse), 32'd256);
      check("wrap_toggle", 32'(toggle), 32'd0);
      check("wrap_cnt_end", 32'(press_cnt), 32'd0);

      // 6: reset in the middle of a held press
      do_reset(1, 1'b0);
      btn_raw = 1'b1;
      for (int k = 0; k < 20; k++) go();
      check("hold_level", 32'(level), 32'd1);
      check("hold_cnt", 32'(press_cnt), 32'd1);
      do_reset(1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         check("rehold_level", 32'(level), 32'(k >= 12));
         check("rehold_pulse", 32'(pulse), 32'(k == 12));
         go();
      end
      check("rehold_cnt", 32'(press_cnt), 32'd1);
      check("rehold_toggle", 32'(toggle), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
